// File: rtl/mem2_ctrl.sv
// MEM->MEM2 boundary sequencer: one data-memory request per load/store,
// bounded response wait, and drain of responses orphaned by a CP0 flush.
module mem2_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic MEM_Valid,
    input  logic MEM_IsMemReq,
    input  logic MEM_ExceptValid,
    input  logic CP0_Flush,
    input  logic DCache_ReqReady,
    input  logic DCache_RespValid,
    output logic DCache_ReqValid,
    output logic MEM_Stall,
    output logic MEM2_Wr,
    output logic MEM2_Flush,
    output logic MEM_TimeoutExc
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic issue;
    logic cnt_last;

    assign issue = MEM_Valid & MEM_IsMemReq & ~MEM_ExceptValid & ~CP0_Flush;
    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        DCache_ReqValid = 1'b0;
        MEM_Stall       = 1'b0;
        MEM2_Wr         = 1'b0;
        MEM2_Flush      = 1'b0;
        MEM_TimeoutExc  = 1'b0;

        if (!rst) begin
            state_nxt  = S_IDLE;
            cnt_nxt    = '0;
            MEM2_Flush = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cnt_nxt = '0;
                    if (CP0_Flush) begin
                        MEM2_Flush = 1'b1;
                    end else if (issue) begin
                        DCache_ReqValid = 1'b1;
                        MEM_Stall       = 1'b1;
                        MEM2_Flush      = 1'b1;
                        state_nxt = DCache_ReqReady ? S_WAIT : S_REQ;
                    end else begin
                        MEM2_Wr = 1'b1;
                    end
                end

                S_REQ: begin
                    cnt_nxt = '0;
                    if (CP0_Flush) begin
                        MEM2_Flush = 1'b1;
                        state_nxt  = S_IDLE;
                    end else begin
                        DCache_ReqValid = 1'b1;
                        MEM_Stall       = 1'b1;
                        MEM2_Flush      = 1'b1;
                        if (DCache_ReqReady) state_nxt = S_WAIT;
                    end
                end

                S_WAIT: begin
                    cnt_nxt = cnt + 1'b1;
                    // A flush kills the owner; an unanswered request must drain
                    if (CP0_Flush) begin
                        MEM2_Flush = 1'b1;
                        if (DCache_RespValid) begin
                            state_nxt = S_IDLE;
                        end else begin
                            state_nxt = S_DRAIN;
                            cnt_nxt   = '0;
                        end
                    end else if (DCache_RespValid) begin
                        MEM2_Wr   = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (cnt_last) begin
                        MEM2_Wr        = 1'b1;
                        MEM_TimeoutExc = 1'b1;
                        state_nxt      = S_DRAIN;
                        cnt_nxt        = '0;
                    end else begin
                        MEM_Stall  = 1'b1;
                        MEM2_Flush = 1'b1;
                    end
                end

                S_DRAIN: begin
                    cnt_nxt = cnt + 1'b1;
                    if (DCache_RespValid || cnt_last) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                    // A new load/store holds until IDLE so requests never overlap
                    if (CP0_Flush) begin
                        MEM2_Flush = 1'b1;
                    end else if (issue) begin
                        MEM_Stall  = 1'b1;
                        MEM2_Flush = 1'b1;
                    end else begin
                        MEM2_Wr = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem2_ctrl.sv
// Scoreboard bench for mem2_ctrl: directed scenarios plus random traffic
// checked against a transaction-level model of the memory handshake.
module tb_mem2_ctrl;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    logic MEM_Valid, MEM_IsMemReq, MEM_ExceptValid, CP0_Flush;
    logic DCache_ReqReady, DCache_RespValid;
    logic DCache_ReqValid, MEM_Stall, MEM2_Wr, MEM2_Flush, MEM_TimeoutExc;

    mem2_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .rst(rst),
        .MEM_Valid(MEM_Valid),
        .MEM_IsMemReq(MEM_IsMemReq),
        .MEM_ExceptValid(MEM_ExceptValid),
        .CP0_Flush(CP0_Flush),
        .DCache_ReqReady(DCache_ReqReady),
        .DCache_RespValid(DCache_RespValid),
        .DCache_ReqValid(DCache_ReqValid),
        .MEM_Stall(MEM_Stall),
        .MEM2_Wr(MEM2_Wr),
        .MEM2_Flush(MEM2_Flush),
        .MEM_TimeoutExc(MEM_TimeoutExc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    logic [4:0] expq[$];
    string tagq[$];
    string tag = "reset";

    // Model of the memory transaction: what is in flight, not how it is encoded
    bit req_up;
    bit owned;
    bit orphan;
    int age;

    task automatic model_step(output logic [4:0] e);
        bit rq, st, wr, fl, tx, iss;
        rq = 0; st = 0; wr = 0; fl = 0; tx = 0;
        iss = MEM_Valid & MEM_IsMemReq & ~MEM_ExceptValid & ~CP0_Flush;
        if (!rst) begin
            fl = 1;
            req_up = 0; owned = 0; orphan = 0; age = 0;
        end else if (owned) begin
            if (CP0_Flush) begin
                fl = 1; owned = 0;
                if (!DCache_RespValid) begin orphan = 1; age = 0; end
            end else if (DCache_RespValid) begin
                wr = 1; owned = 0;
            end else if (age == TO - 1) begin
                wr = 1; tx = 1; owned = 0; orphan = 1; age = 0;
            end else begin
                st = 1; fl = 1; age++;
            end
        end else if (orphan) begin
            if (CP0_Flush) fl = 1;
            else if (iss) begin st = 1; fl = 1; end
            else wr = 1;
            if (DCache_RespValid || age == TO - 1) orphan = 0;
            else age++;
        end else if (req_up) begin
            if (CP0_Flush) begin
                fl = 1; req_up = 0;
            end else begin
                rq = 1; st = 1; fl = 1;
                if (DCache_ReqReady) begin req_up = 0; owned = 1; age = 0; end
            end
        end else begin
            if (CP0_Flush) fl = 1;
            else if (iss) begin
                rq = 1; st = 1; fl = 1;
                if (DCache_ReqReady) begin owned = 1; age = 0; end
                else req_up = 1;
            end else wr = 1;
        end
        e = {rq, st, wr, fl, tx};
    endtask

    task automatic cyc(input logic r, v, m, x, f, rr, rv);
        logic [4:0] e;
        rst = r;
        MEM_Valid = v; MEM_IsMemReq = m; MEM_ExceptValid = x;
        CP0_Flush = f; DCache_ReqReady = rr; DCache_RespValid = rv;
        model_step(e);
        expq.push_back(e);
        tagq.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [4:0] got, e;
        string t;
        cycle++;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            t = tagq.pop_front();
            got = {DCache_ReqValid, MEM_Stall, MEM2_Wr, MEM2_Flush, MEM_TimeoutExc};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s cycle %0d {rq,stall,wr,flush,tmo} got %05b exp %05b",
                         t, cycle, got, e);
            end
        end
    end

    initial begin
        rst = 1'b0;
        MEM_Valid = 0; MEM_IsMemReq = 0; MEM_ExceptValid = 0;
        CP0_Flush = 0; DCache_ReqReady = 0; DCache_RespValid = 0;
        @(posedge clk);
        #1;
        tag = "reset";
        repeat (2) cyc(0, 1, 1, 0, 0, 1, 1);

        tag = "alu8";
        repeat (8) cyc(1, 1, 0, 0, 0, 0, 0);

        tag = "load_k3";
        cyc(1, 1, 1, 0, 0, 1, 0);
        repeat (2) cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0);

        tag = "store_rdy_late";
        repeat (2) cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);

        tag = "flush_drain";
        cyc(1, 1, 1, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0, 1, 1);
        cyc(1, 1, 1, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0, 0, 1);

        tag = "timeout";
        cyc(1, 1, 1, 0, 0, 1, 0);
        repeat (4) cyc(1, 1, 1, 0, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0, 0, 1);

        tag = "reset_in_wait";
        cyc(1, 1, 1, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);

        tag = "random";
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 149) != 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 11) == 0),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0));
        end

        tag = "tail";
        cyc(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d exp 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
